// File: rtl/div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the iterative divider:
//   - div_state_e : FSM state encoding (IDLE / ZERO / RUN / END)
//   - DIV_CYCLES  : number of restoring steps (one per quotient bit)
//   - CNT_W       : width of the iteration counter
//   - magnitude() : absolute value of an operand when treated as signed
//   - apply_sign(): conditional two's-complement negation of a magnitude
// ---------------------------------------------------------------------------
package div_ctrl_pkg;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ZERO = 2'd1,
        ST_RUN  = 2'd2,
        ST_END  = 2'd3
    } div_state_e;

    // Only negative values of a signed operation are negated. The most
    // negative number maps onto 32'h80000000, which is the correct unsigned
    // magnitude 2^31, so no extra bit is needed.
    function automatic logic [31:0] magnitude(input logic [31:0] value,
                                              input logic        is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] mag,
                                               input logic        neg);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_ctrl_if
// Request/response bundle between the EX stage and the divider.
//   start, signed_op, dividend, divisor, cancel : EX stage -> divider
//   stall_req, done, quotient, remainder        : divider  -> pipeline
// Modports:
//   master : the pipeline side (drives requests, observes results)
//   slave  : the divider side
// ---------------------------------------------------------------------------
interface div_ctrl_if;

    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall_req;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    modport master (
        output start,
        output signed_op,
        output dividend,
        output divisor,
        output cancel,
        input  stall_req,
        input  done,
        input  quotient,
        input  remainder
    );

    modport slave (
        input  start,
        input  signed_op,
        input  dividend,
        input  divisor,
        input  cancel,
        output stall_req,
        output done,
        output quotient,
        output remainder
    );

endinterface

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One restoring shift-subtract step on unsigned magnitudes.
// Ports:
//   rem_in  [32:0] : current partial remainder (always < divisor)
//   dsr     [31:0] : divisor magnitude
//   dvd_bit        : next dividend bit, MSB first
//   rem_out [32:0] : partial remainder after this step
//   q_bit          : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step (
    input  logic [32:0] rem_in,
    input  logic [31:0] dsr,
    input  logic        dvd_bit,
    output logic [32:0] rem_out,
    output logic        q_bit
);

    logic [33:0] shifted;
    logic [33:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        // One spare bit above the shifted value so the borrow lands in
        // diff[33] even for a full 32-bit unsigned divisor.
        diff    = shifted - {2'b00, dsr};
        q_bit   = ~diff[33];
        // Restore (keep the shifted value) when the subtraction borrowed.
        rem_out = diff[33] ? shifted[32:0] : diff[32:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// Multi-cycle DIV/DIVU unit for the EX stage. A request accepted in IDLE
// either takes the one-cycle divide-by-zero path (ZERO) or performs 32
// restoring steps on operand magnitudes (RUN); END presents a one-cycle done
// pulse with the sign-corrected quotient/remainder held in output registers.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_ctrl_if.slave
//          start/signed_op/dividend/divisor/cancel in,
//          stall_req/done/quotient/remainder out
// stall_req is combinational so the pipeline freezes in the very cycle the
// divide is accepted; it drops in END so the stalled instruction retires
// together with the done pulse.
// ---------------------------------------------------------------------------
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    div_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    div_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Latched request
    logic             signed_reg;
    logic [31:0]      dividend_reg;  // raw dividend, returned on divide by zero
    logic             dsr_neg_reg;   // divisor was negative in a signed op
    logic [31:0]      dsr_mag_reg;

    // Iteration datapath
    logic [31:0]      dvd_shift_reg; // dividend magnitude, consumed MSB first
    logic [32:0]      rem_reg;       // partial remainder
    logic [31:0]      quo_shift_reg; // quotient magnitude bits, shifted in LSB

    // Registered outputs
    logic             done_reg;
    logic [31:0]      quotient_reg;
    logic [31:0]      remainder_reg;

    // Step results and final-value helpers
    logic [32:0]      step_rem;
    logic             step_qbit;
    logic [31:0]      final_q_mag;
    logic             dvd_neg;
    logic             neg_q;
    logic             neg_r;
    logic             accept;

    div_step u_step (
        .rem_in  (rem_reg),
        .dsr     (dsr_mag_reg),
        .dvd_bit (dvd_shift_reg[31]),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    always_comb begin
        accept      = (state_reg == ST_IDLE) && bus.start && !bus.cancel;
        final_q_mag = {quo_shift_reg[30:0], step_qbit};
        dvd_neg     = signed_reg & dividend_reg[31];
        // -2^31 / -1: both signs negative, so no negation and the magnitude
        // 32'h80000000 passes straight through as the wrapped result.
        neg_q       = dvd_neg ^ dsr_neg_reg;
        neg_r       = dvd_neg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            signed_reg    <= 1'b0;
            dividend_reg  <= '0;
            dsr_neg_reg   <= 1'b0;
            dsr_mag_reg   <= '0;
            dvd_shift_reg <= '0;
            rem_reg       <= '0;
            quo_shift_reg <= '0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        signed_reg    <= bus.signed_op;
                        dividend_reg  <= bus.dividend;
                        dsr_neg_reg   <= bus.signed_op & bus.divisor[31];
                        dsr_mag_reg   <= magnitude(bus.divisor, bus.signed_op);
                        dvd_shift_reg <= magnitude(bus.dividend, bus.signed_op);
                        rem_reg       <= '0;
                        quo_shift_reg <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= (bus.divisor == 32'd0) ? ST_ZERO : ST_RUN;
                    end
                end

                ST_ZERO: begin
                    if (bus.cancel) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        quotient_reg  <= 32'hFFFF_FFFF;
                        remainder_reg <= dividend_reg;
                        done_reg      <= 1'b1;
                        state_reg     <= ST_END;
                    end
                end

                ST_RUN: begin
                    if (bus.cancel) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        rem_reg       <= step_rem;
                        quo_shift_reg <= final_q_mag;
                        dvd_shift_reg <= {dvd_shift_reg[30:0], 1'b0};
                        cnt_reg       <= cnt_reg + CNT_W'(1);
                        // Results are loaded on the last step so they are
                        // already valid while done is high in END.
                        if (cnt_reg == CNT_LAST) begin
                            quotient_reg  <= apply_sign(final_q_mag, neg_q);
                            remainder_reg <= apply_sign(step_rem[31:0], neg_r);
                            done_reg      <= 1'b1;
                            state_reg     <= ST_END;
                        end
                    end
                end

                ST_END: begin
                    // cancel is deliberately ignored: the result is already out.
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.stall_req = (accept && !rst)
                         || (state_reg == ST_ZERO)
                         || (state_reg == ST_RUN);
    assign bus.done      = done_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;

endmodule
